// File: rtl/sc_mul_accum_if.sv
// Handshake bundle for sc_mul_accum: command (start/len), product
// stream (in_*), result stream (out_*) and busy status.
interface sc_mul_accum_if #(
    parameter int IN_WIDTH  = 32,
    parameter int ACC_WIDTH = 40,
    parameter int CNT_WIDTH = 8
);
    logic                 start;
    logic [CNT_WIDTH-1:0] len;
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_sat;
    logic                 busy;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat, busy
    );
endinterface

// File: rtl/sc_mul_accum.sv
// Accumulates len unsigned products into one saturating sum and holds it.
// Ports: clk, rst_n (async active-low), bus (sc_mul_accum_if.slave).
module sc_mul_accum #(
    parameter int IN_WIDTH  = 32,
    parameter int ACC_WIDTH = 40,
    parameter int CNT_WIDTH = 8
) (
    input logic            clk,
    input logic            rst_n,
    sc_mul_accum_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] remaining;
    logic                 sat;
    logic [ACC_WIDTH-1:0] res_data;
    logic                 res_sat;

    logic [ACC_WIDTH:0]   sum;
    logic                 nxt_sat;
    logic [ACC_WIDTH-1:0] nxt_acc;
    logic                 fire;

    always_comb begin
        sum = {1'b0, acc}
            + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, bus.in_data};
        nxt_sat = sat | sum[ACC_WIDTH];
        // once saturated, the sum is pinned at all ones
        nxt_acc = nxt_sat ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
    end

    assign fire = (state == ACCUM) && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            sat       <= 1'b0;
            res_data  <= '0;
            res_sat   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc <= '0;
                        sat <= 1'b0;
                        remaining <= bus.len;
                        if (bus.len == '0) begin
                            // empty dot product publishes zero
                            res_data <= '0;
                            res_sat  <= 1'b0;
                            state    <= HOLD;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (fire) begin
                        acc       <= nxt_acc;
                        sat       <= nxt_sat;
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_WIDTH'(1)) begin
                            res_data <= nxt_acc;
                            res_sat  <= nxt_sat;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == HOLD);
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = res_data;
    assign bus.out_sat   = res_sat;
endmodule

// File: tb/tb_sc_mul_accum.sv
// Directed bench for sc_mul_accum: vector table plus hand sequences.
// Second instance with ACC_WIDTH=32 exercises saturation.
module tb_sc_mul_accum;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sc_mul_accum_if #(.IN_WIDTH(32), .ACC_WIDTH(40), .CNT_WIDTH(8)) ifa ();
    sc_mul_accum_if #(.IN_WIDTH(32), .ACC_WIDTH(32), .CNT_WIDTH(8)) ifb ();

    sc_mul_accum #(.IN_WIDTH(32), .ACC_WIDTH(40), .CNT_WIDTH(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    sc_mul_accum #(.IN_WIDTH(32), .ACC_WIDTH(32), .CNT_WIDTH(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    typedef struct packed {
        logic [7:0]       len;
        logic [3:0][31:0] d;
        logic [39:0]      exp;
        logic             exp_sat;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_a(input vec_t v, input string tag);
        ifa.start = 1'b1;
        ifa.len   = v.len;
        tick();
        ifa.start = 1'b0;
        for (int i = 0; i < int'(v.len); i++) begin
            chk({tag, ".in_ready"}, 64'(ifa.in_ready), 64'd1);
            ifa.in_valid = 1'b1;
            ifa.in_data  = v.d[i];
            tick();
        end
        ifa.in_valid = 1'b0;
        chk({tag, ".out_valid"}, 64'(ifa.out_valid), 64'd1);
        chk({tag, ".in_ready_hold"}, 64'(ifa.in_ready), 64'd0);
        chk({tag, ".out_data"}, 64'(ifa.out_data), 64'(v.exp));
        chk({tag, ".out_sat"}, 64'(ifa.out_sat), 64'(v.exp_sat));
        chk({tag, ".busy"}, 64'(ifa.busy), 64'd1);
        ifa.out_ready = 1'b1;
        tick();
        ifa.out_ready = 1'b0;
        chk({tag, ".idle_busy"}, 64'(ifa.busy), 64'd0);
        chk({tag, ".idle_valid"}, 64'(ifa.out_valid), 64'd0);
        chk({tag, ".kept_data"}, 64'(ifa.out_data), 64'(v.exp));
    endtask

    task automatic run_b(input logic [7:0] n, input logic [3:0][31:0] d,
                         input logic [31:0] exp, input logic exp_sat,
                         input string tag);
        ifb.start = 1'b1;
        ifb.len   = n;
        tick();
        ifb.start = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            ifb.in_valid = 1'b1;
            ifb.in_data  = d[i];
            tick();
        end
        ifb.in_valid = 1'b0;
        chk({tag, ".out_valid"}, 64'(ifb.out_valid), 64'd1);
        chk({tag, ".out_data"}, 64'(ifb.out_data), 64'(exp));
        chk({tag, ".out_sat"}, 64'(ifb.out_sat), 64'(exp_sat));
        ifb.out_ready = 1'b1;
        tick();
        ifb.out_ready = 1'b0;
        chk({tag, ".idle"}, 64'(ifb.busy), 64'd0);
    endtask

    initial begin
        vecs[0] = '{8'd3, {32'd0, 32'd11, 32'd7, 32'd5}, 40'd23, 1'b0};
        vecs[1] = '{8'd0, {32'd9, 32'd9, 32'd9, 32'd9}, 40'd0, 1'b0};
        vecs[2] = '{8'd1, {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF},
                    40'h00_FFFF_FFFF, 1'b0};
        vecs[3] = '{8'd4, {4{32'hFFFF_FFFF}}, 40'h03_FFFF_FFFC, 1'b0};
        vecs[4] = '{8'd2, {32'd0, 32'd0, 32'h8000_0000, 32'h8000_0000},
                    40'h01_0000_0000, 1'b0};
        vecs[5] = '{8'd4, {32'd4, 32'd3, 32'd2, 32'd1}, 40'd10, 1'b0};

        ifa.start = 0; ifa.len = 0; ifa.in_valid = 0;
        ifa.in_data = 0; ifa.out_ready = 0;
        ifb.start = 0; ifb.len = 0; ifb.in_valid = 0;
        ifb.in_data = 0; ifb.out_ready = 0;

        tick();
        tick();
        chk("rst.in_ready", 64'(ifa.in_ready), 64'd0);
        chk("rst.out_valid", 64'(ifa.out_valid), 64'd0);
        chk("rst.out_data", 64'(ifa.out_data), 64'd0);
        chk("rst.out_sat", 64'(ifa.out_sat), 64'd0);
        chk("rst.busy", 64'(ifa.busy), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_a(vecs[i], $sformatf("vec%0d", i));
        end

        // stalls on both sides
        ifa.start = 1'b1;
        ifa.len   = 8'd4;
        tick();
        ifa.start = 1'b0;
        ifa.in_valid = 1; ifa.in_data = 32'd100; tick();
        ifa.in_valid = 0; ifa.in_data = 32'd999; tick();
        chk("stall.in_ready", 64'(ifa.in_ready), 64'd1);
        ifa.in_valid = 1; ifa.in_data = 32'd200; tick();
        ifa.in_valid = 1; ifa.in_data = 32'd300; tick();
        ifa.in_valid = 0; ifa.in_data = 32'd999; tick();
        chk("stall.no_early_hold", 64'(ifa.out_valid), 64'd0);
        ifa.in_valid = 1; ifa.in_data = 32'd400; tick();
        ifa.in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("stall.out_valid", 64'(ifa.out_valid), 64'd1);
            chk("stall.out_data", 64'(ifa.out_data), 64'd1000);
            tick();
        end
        ifa.out_ready = 1'b1;
        tick();
        ifa.out_ready = 1'b0;
        chk("stall.idle", 64'(ifa.busy), 64'd0);

        // start pulses during ACCUM and HOLD are ignored
        ifa.start = 1'b1;
        ifa.len   = 8'd2;
        tick();
        ifa.len = 8'd7;
        ifa.in_valid = 1; ifa.in_data = 32'd10; tick();
        ifa.in_data = 32'd20; tick();
        ifa.in_valid = 0;
        chk("ign.out_valid", 64'(ifa.out_valid), 64'd1);
        chk("ign.out_data", 64'(ifa.out_data), 64'd30);
        tick();
        chk("ign.hold_data", 64'(ifa.out_data), 64'd30);
        ifa.out_ready = 1'b1;
        ifa.start = 1'b0;
        tick();
        ifa.out_ready = 1'b0;
        chk("ign.idle", 64'(ifa.busy), 64'd0);

        // reset mid-run
        ifa.start = 1'b1;
        ifa.len   = 8'd5;
        tick();
        ifa.start = 1'b0;
        ifa.in_valid = 1; ifa.in_data = 32'd3; tick();
        ifa.in_data = 32'd4; tick();
        ifa.in_valid = 0;
        rst_n = 1'b0;
        #1;
        chk("mrst.in_ready", 64'(ifa.in_ready), 64'd0);
        chk("mrst.busy", 64'(ifa.busy), 64'd0);
        chk("mrst.out_data", 64'(ifa.out_data), 64'd0);
        chk("mrst.out_valid", 64'(ifa.out_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_a('{8'd1, {32'd0, 32'd0, 32'd0, 32'd9}, 40'd9, 1'b0}, "mrst9");

        // back-to-back runs with out_ready held high
        ifa.out_ready = 1'b1;
        ifa.in_valid  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            ifa.start   = 1'b1;
            ifa.len     = 8'd1;
            ifa.in_data = 32'(k);
            tick();
            ifa.start = 1'b0;
            chk("b2b.in_ready", 64'(ifa.in_ready), 64'd1);
            tick();
            ifa.in_data = 32'hDEAD;
            chk("b2b.out_valid", 64'(ifa.out_valid), 64'd1);
            chk("b2b.out_data", 64'(ifa.out_data), 64'(k));
            tick();
            chk("b2b.idle", 64'(ifa.busy), 64'd0);
        end
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b0;

        // saturation on the 32-bit accumulator
        run_b(8'd2, {32'd0, 32'd0, 32'h0002_0000, 32'hFFFF_0000},
              32'hFFFF_FFFF, 1'b1, "sat");
        run_b(8'd1, {32'd0, 32'd0, 32'd0, 32'd1}, 32'd1, 1'b0, "unsat");
        run_b(8'd3, {32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF},
              32'hFFFF_FFFF, 1'b1, "sticky");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
